// File: rtl/seq_display_pkg.sv
// Shared digit/segment types and the active-high hex segment table for the sequence display.
package seq_display_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    // Bit order {g,f,e,d,c,b,a}, active-high; index 0 is hex 0.
    localparam seg_t SEG_HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seq_display_scan_hex.sv
// Combinational hex digit to active-high 7-segment lookup; zero latency, no flow control.
module hex_to_seg7
    import seq_display_pkg::*;
(
    input  digit_t digit_i,
    output seg_t   seg_o
);

    assign seg_o = SEG_HEX[digit_i];

endmodule

// File: rtl/seq_display_scan.sv
// History of the last NUM_DIGITS sequence values, scanned onto a muxed 7-segment display.
// Display outputs are registered (1 cycle); load_i is always accepted. Optional: SEQ_DISPLAY_DP_NEWEST_EN.
module seq_display_scan
    import seq_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int COMMON_ANODE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        value_i,
    input  logic                              load_i,
    input  logic                              clear_i,
    output logic [6:0]                        seg_o,
    output logic                              dp_o,
    output logic [NUM_DIGITS-1:0]             an_o,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   fill_o
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FILL_W = $clog2(NUM_DIGITS + 1);
    localparam int CNT_W  = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(NUM_DIGITS);

    // Inactive level of every display output: high for common-anode parts.
    localparam logic                  ACT_LOW  = (COMMON_ANODE != 0);
    localparam seg_t                  SEG_OFF  = SEG_BLANK ^ {7{ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACT_LOW}};

    logic [CNT_W-1:0]                 cnt_q,  cnt_d;
    logic [IDX_W-1:0]                 idx_q,  idx_d;
    logic [FILL_W-1:0]                fill_q, fill_d;
    digit_t [NUM_DIGITS-1:0]          hist_q, hist_d;
    seg_t                             seg_q,  seg_d;
    logic [NUM_DIGITS-1:0]            an_q,   an_d;

    logic                             tick;
    logic                             lit;
    digit_t                           cur_digit;
    seg_t                             cur_seg;
    logic [NUM_DIGITS-1:0]            an_hot;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Clear dominates load; the prescaler keeps running regardless.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (load_i) begin
            hist_d[0] = value_i;
            for (int k = 1; k < NUM_DIGITS; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    assign cur_digit = hist_q[idx_q];

    hex_to_seg7 u_hex (
        .digit_i (cur_digit),
        .seg_o   (cur_seg)
    );

    // Slots at or beyond the fill count were never loaded and stay dark.
    always_comb begin
        lit    = (FILL_W'(idx_q) < fill_q);
        an_hot = NUM_DIGITS'(1) << idx_q;
        seg_d  = SEG_OFF;
        an_d   = AN_OFF;
        if (lit) begin
            seg_d = cur_seg ^ {7{ACT_LOW}};
            an_d  = an_hot ^ AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            fill_q <= '0;
            hist_q <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            fill_q <= fill_d;
            hist_q <= hist_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign fill_o = fill_q;

`ifdef SEQ_DISPLAY_DP_NEWEST_EN
    logic dp_q, dp_d;

    // Marks the newest value: slot 0 whenever anything has been loaded.
    assign dp_d = ((idx_q == '0) && (fill_q != '0)) ^ ACT_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_q <= ACT_LOW;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp_o = dp_q;
`else
    assign dp_o = ACT_LOW;
`endif

endmodule

// File: tb/tb_seq_display_scan.sv
// Directed bench for seq_display_scan with NUM_DIGITS=4, SCAN_DIV=4, COMMON_ANODE=1.
module tb_seq_display_scan;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic [3:0] value_i = 4'd0;
    logic       load_i  = 1'b0;
    logic       clear_i = 1'b0;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [3:0] an_o;
    logic [2:0] fill_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef SEQ_DISPLAY_DP_NEWEST_EN
    localparam logic DP0 = 1'b0;
`else
    localparam logic DP0 = 1'b1;
`endif

    localparam logic [6:0] OFF = 7'b1111111;

    seq_display_scan #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .COMMON_ANODE (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .load_i  (load_i),
        .clear_i (clear_i),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o),
        .fill_o  (fill_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Slot shown on the outputs after edge cyc (display lags the scan index by one edge).
    function automatic int shown_slot();
        return ((cyc - 1) / 4) % 4;
    endfunction

    task automatic goto_slot(input int s);
        int n;
        n = 0;
        tick();
        while (shown_slot() != s && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] seg, input logic [3:0] an, input logic dp);
        checks++;
        assert (seg_o === seg) else begin
            errors++;
            $error("FAIL %s seg_o: observed %b expected %b", tag, seg_o, seg);
        end
        checks++;
        assert (an_o === an) else begin
            errors++;
            $error("FAIL %s an_o: observed %b expected %b", tag, an_o, an);
        end
        checks++;
        assert (dp_o === dp) else begin
            errors++;
            $error("FAIL %s dp_o: observed %b expected %b", tag, dp_o, dp);
        end
    endtask

    task automatic chk_fill(input string tag, input logic [2:0] f);
        checks++;
        assert (fill_o === f) else begin
            errors++;
            $error("FAIL %s fill_o: observed %0d expected %0d", tag, fill_o, f);
        end
    endtask

    task automatic load(input logic [3:0] v);
        value_i = v;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
    endtask

    task automatic blank_all(input string tag);
        for (int s = 0; s < 4; s++) begin
            goto_slot(s);
            chk(tag, OFF, 4'b1111, 1'b1);
        end
    endtask

    initial begin
        // Power-on reset
        #2 rst = 1'b1;
        #1;
        chk("por", OFF, 4'b1111, 1'b1);
        chk_fill("por_fill", 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;

        // Single load of 4
        load(4'd4);
        chk_fill("single_fill", 3'd1);
        goto_slot(0);
        chk("single_s0", 7'b0011001, 4'b1110, DP0);
        goto_slot(1);
        chk("single_s1", OFF, 4'b1111, 1'b1);
        goto_slot(2);
        chk("single_s2", OFF, 4'b1111, 1'b1);
        goto_slot(3);
        chk("single_s3", OFF, 4'b1111, 1'b1);

        // Reset in the middle of a lit slot
        goto_slot(0);
        tick();
        chk("pre_rst_s0", 7'b0011001, 4'b1110, DP0);
        rst = 1'b1;
        #1;
        chk("midrst", OFF, 4'b1111, 1'b1);
        chk_fill("midrst_fill", 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        blank_all("after_rst");

        // History order
        load(4'd4);
        load(4'd8);
        load(4'd12);
        load(4'd0);
        chk_fill("hist_fill", 3'd4);
        goto_slot(0);
        chk("hist_s0", 7'b1000000, 4'b1110, DP0);
        goto_slot(1);
        chk("hist_s1", 7'b1000110, 4'b1101, 1'b1);
        goto_slot(2);
        chk("hist_s2", 7'b0000000, 4'b1011, 1'b1);
        goto_slot(3);
        chk("hist_s3", 7'b0011001, 4'b0111, 1'b1);

        // Saturation: 4 drops out, 3 becomes newest
        load(4'd3);
        chk_fill("sat_fill", 3'd4);
        goto_slot(0);
        chk("sat_s0", 7'b0110000, 4'b1110, DP0);
        goto_slot(1);
        chk("sat_s1", 7'b1000000, 4'b1101, 1'b1);
        goto_slot(3);
        chk("sat_s3", 7'b0000000, 4'b0111, 1'b1);

        // Clear wins over a simultaneous load
        value_i = 4'd15;
        load_i  = 1'b1;
        clear_i = 1'b1;
        tick();
        load_i  = 1'b0;
        clear_i = 1'b0;
        chk_fill("clr_fill", 3'd0);
        blank_all("clr");

        // Load on the same edge as a scan tick into slot 0
        while (cyc % 16 != 15) tick();
        load(4'd5);
        chk_fill("coll_fill", 3'd1);
        chk("coll_edge", OFF, 4'b1111, 1'b1);
        tick();
        chk("coll_s0_first", 7'b0010010, 4'b1110, DP0);
        tick();
        tick();
        tick();
        chk("coll_s0_last", 7'b0010010, 4'b1110, DP0);
        tick();
        chk("coll_s1", OFF, 4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_display_scan.md
Name: seq_display_scan

Overview:
- Downstream consumer of the 4-bit sequence-step value produced by the up/down sequence FSM.
- Keeps a shift history of the last NUM_DIGITS loaded values.
- Drives them onto a time-multiplexed 7-segment display (digit 0 = newest). Digits never loaded stay blank.
- Contains a prescaled scan counter, a history shift register, a fill counter and registered display outputs.

Parameters:
- NUM_DIGITS, 4: number of display digits and history depth; legal range 2..8.
- SCAN_DIV, 50000: clk cycles per digit slot; must be >= 2.
- COMMON_ANODE, 1: 1 = seg_o, dp_o and an_o are active-low; 0 = all active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- value_i  in  4  sequence value from the upstream FSM
- load_i  in  1  single-cycle strobe; value_i is valid and is pushed into history
- clear_i  in  1  synchronous clear of history and fill count
- seg_o  out  7  segment pattern, bit order {g,f,e,d,c,b,a}
- dp_o  out  1  decimal point
- an_o  out  NUM_DIGITS  digit enables, one-hot when active
- fill_o  out  $clog2(NUM_DIGITS+1)  number of valid history entries

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, scan index=0, all history=0, fill=0.
  - seg_o, dp_o and an_o at inactive level: all 1s when COMMON_ANODE=1, all 0s otherwise.
  - fill_o=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle where count==SCAN_DIV-1.
  - On tick, the scan index advances; NUM_DIGITS-1 wraps to 0.
- History load:
  - On a clk edge with load_i=1 and clear_i=0: hist[0]<=value_i, hist[k]<=hist[k-1], fill<=min(fill+1, NUM_DIGITS).
  - At fill==NUM_DIGITS the fill count saturates and the oldest entry is discarded.
- Clear:
  - clear_i=1 sets all hist=0 and fill=0 on the next edge.
  - clear_i wins over a simultaneous load_i; the load is dropped.
  - The prescaler and scan index are unaffected.
- Display pipeline:
  - seg_o, dp_o and an_o are registered from the current scan index and history: 1-cycle latency.
  - A load at edge n is visible on seg_o at edge n+1 if its digit is currently selected.
- Blanking:
  - If scan index >= fill, seg_o and an_o are held inactive for that slot.
  - Otherwise an_o[index] is active and seg_o = hex pattern of hist[index].
- Hex patterns, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - These are inverted when COMMON_ANODE=1.
- dp_o is inactive unless enabled by the optional feature.
- A tick coinciding with load_i: both take effect on the same edge, with no lost load or skipped slot.
- Reset mid-scan returns to index 0 with a blank display.

Optional Feature:
- Macro SEQ_DISPLAY_DP_NEWEST_EN.
- Defined: dp_o is active while scan index==0 and fill>0, marking the newest value.
- Undefined: dp_o is tied to the inactive level and no logic is generated for it.

Decomposition:
- Package seq_display_pkg:
  - typedef digit_t (logic [3:0]) and typedef seg_t (logic [6:0]).
  - Constant SEG_HEX[16] of seg_t holding the active-high patterns.
  - Constant SEG_BLANK.
- One natural sub-module: hex_to_seg7, a combinational digit_t to seg_t lookup using SEG_HEX.
  - Instantiated once, on the muxed history entry.

Test Plan (all scenarios use SCAN_DIV=4, NUM_DIGITS=4, COMMON_ANODE=1):
- Reset check: assert rst mid-scan -> seg_o=1111111, an_o=1111, dp_o=1, fill_o=0 immediately, and stay there through all 4 slots.
- Single load: load value_i=4 -> fill_o=1; slot 0 shows an_o=1110, seg_o=0011001; slots 1-3 show an_o=1111.
- History order: load 4, 8, 12, 0 -> slot 0 shows 1000000 ("0"), slot 1 shows 1000110 ("C"), slot 2 shows 0000000 ("8"), slot 3 shows 0011001 ("4").
- Saturation: load 4, 8, 12, 0, 3 -> fill_o stays 4, slot 0 shows 0110000 ("3"), and "4" is discarded.
- Clear vs load: clear_i=1 and load_i=1 with value_i=15 in the same cycle -> fill_o=0 and all slots blank.
- Collision and feature:
  - Load in the same cycle as a tick -> the value appears in slot 0 one cycle after the edge, and no slot is skipped.
  - With SEQ_DISPLAY_DP_NEWEST_EN defined, dp_o=0 only during slot 0 when fill>0.
